// File: rtl/ipv4_pkg.sv
// Shared constants and types for the IPv4 transmit path.
// Covers beat geometry, arbiter state encoding and inter-packet gap counter width.
package ipv4_pkg;

   localparam int IPV4_DATA_W = 16;
   localparam int IPV4_LEN_W  = $clog2(IPV4_DATA_W / 8);
   localparam int IPG_CNT_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_GAP  = 2'd2
   } tx_state_e;

   // A single requester still needs a 1-bit pointer.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Returns the first set request at or after ptr as a one-hot grant, or zero.
module rr_pick
   import ipv4_pkg::*;
#(
   parameter int REQ_N = 2,
   parameter int PTR_W = ptr_width(REQ_N)
) (
   input  logic [PTR_W-1:0] ptr,
   input  logic [REQ_N-1:0] req,
   output logic [REQ_N-1:0] grant
);

   logic             found;
   logic [PTR_W-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < REQ_N; i++) begin
         idx = PTR_W'((int'(ptr) + i) % REQ_N);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ipv4_tx_arb.sv
// Packet-level round-robin arbiter feeding the IPv4 TX path.
// Owns one requester per packet and forces an inter-packet gap after each one.
module ipv4_tx_arb
   import ipv4_pkg::*;
#(
   parameter int DATA_W  = IPV4_DATA_W,
   parameter int LEN_W   = $clog2(DATA_W / 8),
   parameter int REQ_N   = 2,
   parameter int IPG_CYC = 2
) (
   input  logic                    clk,
   input  logic                    nreset,
   input  logic [REQ_N-1:0]        req_valid_i,
   input  logic [REQ_N*DATA_W-1:0] req_data_i,
   input  logic [REQ_N*LEN_W-1:0]  req_len_i,
   input  logic [REQ_N-1:0]        req_last_i,
   input  logic [REQ_N-1:0]        req_cancel_i,
   output logic [REQ_N-1:0]        req_ready_o,
   output logic                    valid_o,
   output logic [DATA_W-1:0]       data_o,
   output logic [LEN_W-1:0]        len_o,
   output logic                    last_o,
   output logic                    cancel_o,
   input  logic                    ready_i,
   output logic [REQ_N-1:0]        grant_o
);

   localparam int PTR_W = ptr_width(REQ_N);

   tx_state_e              state_q, state_d;
   logic [REQ_N-1:0]       grant_q, grant_d;
   logic [PTR_W-1:0]       ptr_q, ptr_d;
   logic [IPG_CNT_W-1:0]   gap_q, gap_d;

   logic [REQ_N-1:0]       pick;
   logic [PTR_W-1:0]       g_idx;
   logic [DATA_W-1:0]      sel_data;
   logic [LEN_W-1:0]       sel_len;
   logic                   sel_valid;
   logic                   sel_last;
   logic                   sel_cancel;
   logic                   end_pkt;

   rr_pick #(
      .REQ_N (REQ_N),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .ptr   (ptr_q),
      .req   (req_valid_i),
      .grant (pick)
   );

   assign grant_o = grant_q;

   // Steer the owning requester's beat onto the shared output.
   always_comb begin
      g_idx      = '0;
      sel_data   = '0;
      sel_len    = '0;
      sel_valid  = 1'b0;
      sel_last   = 1'b0;
      sel_cancel = 1'b0;
      for (int i = 0; i < REQ_N; i++) begin
         if (grant_q[i]) begin
            g_idx      = PTR_W'(i);
            sel_data   = req_data_i[i*DATA_W +: DATA_W];
            sel_len    = req_len_i[i*LEN_W +: LEN_W];
            sel_valid  = req_valid_i[i];
            sel_last   = req_last_i[i];
            sel_cancel = req_cancel_i[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         gap_q   <= gap_d;
      end
   end

   // A cancel wins over a simultaneous last beat; both close the packet.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      ptr_d       = ptr_q;
      gap_d       = gap_q;
      valid_o     = 1'b0;
      last_o      = 1'b0;
      cancel_o    = 1'b0;
      req_ready_o = '0;
      data_o      = sel_data;
      len_o       = sel_len;
      end_pkt     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (|req_valid_i) begin
               grant_d = pick;
               state_d = ST_XFER;
            end
         end
         ST_XFER: begin
            cancel_o    = sel_cancel;
            valid_o     = sel_valid & ~sel_cancel;
            last_o      = sel_last & valid_o;
            req_ready_o = grant_q & {REQ_N{ready_i}};
            end_pkt     = sel_cancel | (valid_o & ready_i & sel_last);
            if (end_pkt) begin
               grant_d = '0;
               ptr_d   = PTR_W'((int'(g_idx) + 1) % REQ_N);
               if (IPG_CYC == 0) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_GAP;
                  gap_d   = IPG_CNT_W'(IPG_CYC);
               end
            end
         end
         ST_GAP: begin
            gap_d = gap_q - IPG_CNT_W'(1);
            if (gap_q <= IPG_CNT_W'(1)) begin
               gap_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase

      // Outputs stay quiet during reset so a dropped packet never shows a cancel.
      if (!nreset) begin
         valid_o     = 1'b0;
         last_o      = 1'b0;
         cancel_o    = 1'b0;
         req_ready_o = '0;
      end
   end

endmodule

// File: tb/tb_ipv4_tx_arb.sv
// Directed self-checking bench for ipv4_tx_arb.
// One instance runs with a 2-cycle gap, a second with no gap.
module tb_ipv4_tx_arb;

   logic        clk = 1'b0;
   logic        nreset;

   logic [1:0]  req_valid, req_last, req_cancel, req_len, req_ready;
   logic [31:0] req_data;
   logic        ready, valid, last, cancel;
   logic [15:0] data;
   logic [0:0]  len;
   logic [1:0]  grant;

   logic [1:0]  z_req_valid, z_req_last, z_req_cancel, z_req_len, z_req_ready;
   logic [31:0] z_req_data;
   logic        z_ready, z_valid, z_last, z_cancel;
   logic [15:0] z_data;
   logic [0:0]  z_len;
   logic [1:0]  z_grant;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ipv4_tx_arb #(.DATA_W(16), .LEN_W(1), .REQ_N(2), .IPG_CYC(2)) dut (
      .clk(clk), .nreset(nreset),
      .req_valid_i(req_valid), .req_data_i(req_data), .req_len_i(req_len),
      .req_last_i(req_last), .req_cancel_i(req_cancel), .req_ready_o(req_ready),
      .valid_o(valid), .data_o(data), .len_o(len), .last_o(last),
      .cancel_o(cancel), .ready_i(ready), .grant_o(grant)
   );

   ipv4_tx_arb #(.DATA_W(16), .LEN_W(1), .REQ_N(2), .IPG_CYC(0)) dut_ipg0 (
      .clk(clk), .nreset(nreset),
      .req_valid_i(z_req_valid), .req_data_i(z_req_data), .req_len_i(z_req_len),
      .req_last_i(z_req_last), .req_cancel_i(z_req_cancel), .req_ready_o(z_req_ready),
      .valid_o(z_valid), .data_o(z_data), .len_o(z_len), .last_o(z_last),
      .cancel_o(z_cancel), .ready_i(z_ready), .grant_o(z_grant)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_valid = '0; req_last = '0; req_cancel = '0; req_len = '0;
      req_data = '0; ready = 1'b0;
      z_req_valid = '0; z_req_last = '0; z_req_cancel = '0; z_req_len = '0;
      z_req_data = '0; z_ready = 1'b0;
   endtask

   task automatic reset_dut();
      clear_inputs();
      nreset = 1'b0;
      tick();
      tick();
      nreset = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      nreset = 1'b0;
      req_valid = 2'b11; req_last = 2'b11; req_cancel = 2'b11; ready = 1'b1;
      tick();
      tick();
      checks++; if (grant !== 2'b00) begin failures++; $display("[TB] FAIL rst_grant got=%b exp=00", grant); end
      checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid got=%b exp=0", valid); end
      checks++; if (req_ready !== 2'b00) begin failures++; $display("[TB] FAIL rst_req_ready got=%b exp=00", req_ready); end
      checks++; if (cancel !== 1'b0) begin failures++; $display("[TB] FAIL rst_cancel got=%b exp=0", cancel); end
      checks++; if (last !== 1'b0) begin failures++; $display("[TB] FAIL rst_last got=%b exp=0", last); end
      clear_inputs();
      nreset = 1'b1;
   endtask

   task automatic test_single();
      reset_dut();
      req_valid = 2'b01; req_data[15:0] = 16'h1111; req_len[0] = 1'b1; ready = 1'b1;
      #1;
      checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL single_idle_valid got=%b exp=0", valid); end
      checks++; if (grant !== 2'b00) begin failures++; $display("[TB] FAIL single_idle_grant got=%b exp=00", grant); end
      tick();
      #1;
      checks++; if (grant !== 2'b01) begin failures++; $display("[TB] FAIL single_grant got=%b exp=01", grant); end
      checks++; if (valid !== 1'b1) begin failures++; $display("[TB] FAIL single_valid got=%b exp=1", valid); end
      checks++; if (data !== 16'h1111) begin failures++; $display("[TB] FAIL single_beat0 got=%h exp=1111", data); end
      checks++; if (len !== 1'b1) begin failures++; $display("[TB] FAIL single_len got=%b exp=1", len); end
      checks++; if (req_ready !== 2'b01) begin failures++; $display("[TB] FAIL single_req_ready got=%b exp=01", req_ready); end
      tick();
      req_data[15:0] = 16'h2222;
      #1;
      checks++; if (data !== 16'h2222) begin failures++; $display("[TB] FAIL single_beat1 got=%h exp=2222", data); end
      checks++; if (last !== 1'b0) begin failures++; $display("[TB] FAIL single_beat1_last got=%b exp=0", last); end
      tick();
      req_data[15:0] = 16'h3333; req_last[0] = 1'b1; req_len[0] = 1'b0;
      #1;
      checks++; if (data !== 16'h3333) begin failures++; $display("[TB] FAIL single_beat2 got=%h exp=3333", data); end
      checks++; if (last !== 1'b1) begin failures++; $display("[TB] FAIL single_last got=%b exp=1", last); end
      checks++; if (len !== 1'b0) begin failures++; $display("[TB] FAIL single_len_last got=%b exp=0", len); end
      tick();
      req_data[15:0] = 16'h4444;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL single_gap_valid[%0d] got=%b exp=0", k, valid); end
         checks++; if (grant !== 2'b00) begin failures++; $display("[TB] FAIL single_gap_grant[%0d] got=%b exp=00", k, grant); end
         checks++; if (req_ready !== 2'b00) begin failures++; $display("[TB] FAIL single_gap_ready[%0d] got=%b exp=00", k, req_ready); end
         tick();
      end
      #1;
      checks++; if (grant !== 2'b01) begin failures++; $display("[TB] FAIL single_regrant got=%b exp=01", grant); end
      checks++; if (data !== 16'h4444) begin failures++; $display("[TB] FAIL single_pkt2 got=%h exp=4444", data); end
      tick();
      req_valid = 2'b00;
      #1;
      checks++; if (grant !== 2'b00) begin failures++; $display("[TB] FAIL single_after got=%b exp=00", grant); end
   endtask

   task automatic test_alternate();
      int          cnt0, cnt1, pkt, beat, cyc, own;
      logic [1:0]  hs;
      logic [15:0] exp_d;
      reset_dut();
      cnt0 = 0; cnt1 = 0; pkt = 0; beat = 0; cyc = 0;
      req_valid = 2'b11; req_len = 2'b11; ready = 1'b1;
      while (pkt < 3 && cyc < 40) begin
         req_data = {16'hB000 + 16'(cnt1), 16'hA000 + 16'(cnt0)};
         req_last = {cnt1 == 1, cnt0 == 1};
         #1;
         if (valid && ready) begin
            own   = pkt % 2;
            exp_d = ((own == 1) ? 16'hB000 : 16'hA000) + 16'(beat);
            checks++; if (grant !== (2'b01 << own)) begin failures++; $display("[TB] FAIL alt_owner pkt%0d got=%b exp_req=%0d", pkt, grant, own); end
            checks++; if (data !== exp_d) begin failures++; $display("[TB] FAIL alt_data pkt%0d got=%h exp=%h", pkt, data, exp_d); end
            checks++; if (last !== (beat == 1)) begin failures++; $display("[TB] FAIL alt_last pkt%0d got=%b exp=%b", pkt, last, beat == 1); end
            beat++;
            if (beat == 2) begin
               beat = 0;
               pkt++;
            end
         end
         hs = req_ready & req_valid;
         tick();
         if (hs[0]) cnt0 = (cnt0 + 1) % 2;
         if (hs[1]) cnt1 = (cnt1 + 1) % 2;
         cyc++;
      end
      checks++; if (pkt != 3) begin failures++; $display("[TB] FAIL alt_timeout packets got=%0d exp=3", pkt); end
      clear_inputs();
   endtask

   task automatic test_stall();
      reset_dut();
      req_valid = 2'b01; req_data[15:0] = 16'hD000; ready = 1'b1;
      tick();
      #1;
      checks++; if (data !== 16'hD000 || req_ready !== 2'b01) begin failures++; $display("[TB] FAIL stall_beat0 got=%h/%b exp=d000/01", data, req_ready); end
      tick();
      req_data[15:0] = 16'hD001; ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++; if (data !== 16'hD001) begin failures++; $display("[TB] FAIL stall_data[%0d] got=%h exp=d001", k, data); end
         checks++; if (req_ready !== 2'b00) begin failures++; $display("[TB] FAIL stall_ready[%0d] got=%b exp=00", k, req_ready); end
         checks++; if (valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_valid[%0d] got=%b exp=1", k, valid); end
         tick();
      end
      ready = 1'b1;
      #1;
      checks++; if (data !== 16'hD001 || req_ready !== 2'b01) begin failures++; $display("[TB] FAIL stall_resume got=%h/%b exp=d001/01", data, req_ready); end
      tick();
      req_data[15:0] = 16'hD002; req_last[0] = 1'b1;
      #1;
      checks++; if (data !== 16'hD002 || last !== 1'b1) begin failures++; $display("[TB] FAIL stall_last got=%h/%b exp=d002/1", data, last); end
      tick();
      req_valid = 2'b00; req_last = 2'b00;
      #1;
      checks++; if (grant !== 2'b00 || valid !== 1'b0) begin failures++; $display("[TB] FAIL stall_end got=%b/%b exp=00/0", grant, valid); end
   endtask

   task automatic test_cancel();
      reset_dut();
      req_valid = 2'b10; req_data[31:16] = 16'hB0B0; ready = 1'b1;
      #1;
      checks++; if (grant !== 2'b00) begin failures++; $display("[TB] FAIL cancel_idle_grant got=%b exp=00", grant); end
      tick();
      req_cancel = 2'b01;
      #1;
      checks++; if (grant !== 2'b10) begin failures++; $display("[TB] FAIL cancel_grant got=%b exp=10", grant); end
      checks++; if (cancel !== 1'b0 || valid !== 1'b1) begin failures++; $display("[TB] FAIL cancel_foreign got=%b/%b exp=0/1", cancel, valid); end
      checks++; if (data !== 16'hB0B0) begin failures++; $display("[TB] FAIL cancel_beat0 got=%h exp=b0b0", data); end
      tick();
      req_cancel = 2'b10; req_last = 2'b10; req_data[31:16] = 16'hB1B1;
      #1;
      checks++; if (cancel !== 1'b1) begin failures++; $display("[TB] FAIL cancel_out got=%b exp=1", cancel); end
      checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL cancel_valid got=%b exp=0", valid); end
      checks++; if (last !== 1'b0) begin failures++; $display("[TB] FAIL cancel_last got=%b exp=0", last); end
      tick();
      req_cancel = 2'b00; req_last = 2'b00; req_valid = 2'b11;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (grant !== 2'b00 || cancel !== 1'b0) begin failures++; $display("[TB] FAIL cancel_gap[%0d] got=%b/%b exp=00/0", k, grant, cancel); end
         tick();
      end
      #1;
      checks++; if (grant !== 2'b01) begin failures++; $display("[TB] FAIL cancel_ptr got=%b exp=01", grant); end
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      reset_dut();
      req_valid = 2'b01; req_data[15:0] = 16'h5550; ready = 1'b1;
      tick();
      #1;
      checks++; if (valid !== 1'b1 || data !== 16'h5550) begin failures++; $display("[TB] FAIL rstmid_beat0 got=%b/%h exp=1/5550", valid, data); end
      tick();
      req_data[15:0] = 16'h5551; nreset = 1'b0;
      #1;
      checks++; if (cancel !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_cancel_in got=%b exp=0", cancel); end
      tick();
      nreset = 1'b1;
      #1;
      checks++; if (valid !== 1'b0 || last !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_valid got=%b/%b exp=0/0", valid, last); end
      checks++; if (grant !== 2'b00 || req_ready !== 2'b00) begin failures++; $display("[TB] FAIL rstmid_grant got=%b/%b exp=00/00", grant, req_ready); end
      checks++; if (cancel !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_cancel_after got=%b exp=0", cancel); end
      tick();
      #1;
      checks++; if (grant !== 2'b01 || cancel !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_restart got=%b/%b exp=01/0", grant, cancel); end
      clear_inputs();
   endtask

   task automatic test_ipg0();
      bit exp_v [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      bit exp_l [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      int zc;
      logic hs;
      reset_dut();
      zc = 0;
      z_req_valid = 2'b01; z_ready = 1'b1;
      for (int k = 0; k < 7; k++) begin
         z_req_data[15:0] = 16'hC000 + 16'(zc);
         z_req_last[0] = (zc == 1);
         #1;
         checks++; if (z_valid !== exp_v[k]) begin failures++; $display("[TB] FAIL ipg0_valid[%0d] got=%b exp=%b", k, z_valid, exp_v[k]); end
         checks++; if (z_last !== exp_l[k]) begin failures++; $display("[TB] FAIL ipg0_last[%0d] got=%b exp=%b", k, z_last, exp_l[k]); end
         hs = z_req_ready[0] & z_req_valid[0];
         tick();
         if (hs) zc = (zc + 1) % 2;
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      nreset = 1'b0;
      test_reset();
      test_single();
      test_alternate();
      test_stall();
      test_cancel();
      test_reset_mid();
      test_ipg0();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ipv4_tx_arb.md
IPV4_TX_ARB -- requirements
Module: ipv4_tx_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning data beat width in bits; only 16 is supported.
REQ-002 SHALL have parameter LEN_W, default $clog2(DATA_W/8), meaning the width of the valid-byte count.
REQ-003 SHALL have parameter REQ_N, default 2, meaning the number of transport requesters (2..4).
REQ-004 SHALL have parameter IPG_CYC, default 2, meaning the idle cycles forced after each packet (0..15).
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port nreset, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port req_valid_i, input, REQ_N bits: per-requester beat valid.
REQ-008 SHALL have port req_data_i, input, REQ_N*DATA_W bits: per-requester beat data.
REQ-009 SHALL have port req_len_i, input, REQ_N*LEN_W bits: per-requester valid-byte count.
REQ-010 SHALL have port req_last_i, input, REQ_N bits: per-requester last beat of packet.
REQ-011 SHALL have port req_cancel_i, input, REQ_N bits: per-requester abort of the packet in flight.
REQ-012 SHALL have port req_ready_o, output, REQ_N bits: beat accepted from that requester.
REQ-013 SHALL have port valid_o, output, 1 bit: beat valid toward the IPv4 TX path.
REQ-014 SHALL have port data_o, output, DATA_W bits: beat data.
REQ-015 SHALL have port len_o, output, LEN_W bits: valid-byte count.
REQ-016 SHALL have port last_o, output, 1 bit: last beat.
REQ-017 SHALL have port cancel_o, output, 1 bit: abort of the forwarded packet.
REQ-018 SHALL have port ready_i, input, 1 bit: downstream accepts the beat.
REQ-019 SHALL have port grant_o, output, REQ_N bits: one-hot current owner, all zero when no packet is owned.

Function
REQ-020 SHALL implement an FSM with states IDLE, XFER and GAP.
REQ-021 In IDLE with any req_valid_i set, SHALL select one requester by round-robin starting at the priority pointer and enter XFER on the next cycle with grant_o registered; there is 1 cycle of grant latency and no beat passes in IDLE.
REQ-022 In XFER, SHALL drive valid_o, data_o, len_o and last_o combinationally from the granted requester, and drive req_ready_o[g] = ready_i; all other req_ready_o bits SHALL be 0.
REQ-023 A beat transfers when valid_o and ready_i are both 1; grant SHALL stay locked until a transfer with last_o=1.
REQ-024 On the last-beat transfer, SHALL clear grant_o, set the pointer to (g+1) mod REQ_N, and enter GAP, or enter IDLE directly if IPG_CYC=0.
REQ-025 GAP SHALL last exactly IPG_CYC cycles, counted by a 4-bit down-counter; valid_o=0 and all req_ready_o=0 during GAP; then enter IDLE.
REQ-026 req_cancel_i[g] in XFER SHALL assert cancel_o for that same cycle, suppress valid_o, end the packet and follow the REQ-024 path; cancel from a non-granted requester SHALL be ignored.
REQ-027 Simultaneous last-beat transfer and cancel SHALL be treated as a cancel.
REQ-028 With a single active requester, packets SHALL be spaced exactly 1 + IPG_CYC idle cycles apart (1 IDLE cycle plus the gap).
REQ-029 Outside XFER, valid_o, last_o and cancel_o SHALL be 0; data_o and len_o are don't-care.

Reset
REQ-030 While nreset=0 at a clk edge: state becomes IDLE, pointer 0, gap counter 0, grant_o 0.
REQ-031 Outputs SHALL be 0 while in reset: valid_o, last_o, cancel_o, req_ready_o.
REQ-032 Reset mid-packet SHALL drop the packet silently, with no cancel_o.

Structure
REQ-033 DATA_W, LEN_W, the state encoding and the IPG counter width SHALL live in shared package ipv4_pkg.
REQ-034 Round-robin selection SHALL be the sub-module rr_pick: a pointer plus request vector in, a one-hot grant out, purely combinational.

Verification
REQ-035 Scenario: req0 sends a 3-beat packet while req1 is idle, IPG_CYC=2 -> grant_o=01 one cycle after valid, 3 beats with data passed through, 2 GAP cycles, then IDLE.
REQ-036 Scenario: both requesters continuously valid -> packets alternate req0, req1, req0, with no interleaving of beats.
REQ-037 Scenario: ready_i held low for 4 cycles mid-packet -> data_o stable, req_ready_o[g]=0, no beat lost or duplicated.
REQ-038 Scenario: req1 asserts cancel on its 2nd beat -> cancel_o=1 for 1 cycle, valid_o=0 in that cycle, pointer moves to 0.
REQ-039 Scenario: nreset pulsed during beat 2 of a packet -> all outputs 0 on the next cycle and cancel_o never asserted.
REQ-040 Scenario: IPG_CYC=0 with req0 continuously valid -> exactly one idle cycle between consecutive packets.
